// File: rtl/popcount_seq_if.sv
// Word-in / count-out handshake bundle for the sequential popcount block.
// The slave side is the popcount block; the master side is the producer/consumer pair.
interface popcount_seq_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] I;
    logic             O_valid;
    logic             O_ready;
    logic [CW-1:0]    O;

    modport slave (
        input  I_valid,
        input  I,
        input  O_ready,
        output I_ready,
        output O_valid,
        output O
    );

    modport master (
        output I_valid,
        output I,
        output O_ready,
        input  I_ready,
        input  O_valid,
        input  O
    );
endinterface

// File: rtl/popcount_seq.sv
// Multi-cycle population count: one shared 8-bit popcount is applied to the
// accepted word one byte per cycle, and the partial counts are summed.
module popcount8 (
    input  logic [7:0] d,
    output logic [3:0] cnt
);
    // Count the set bits of one byte.
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, d[i]};
        end
    end
endmodule

module popcount_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    popcount_seq_if.slave  bus,
    output logic           busy
);
    localparam int unsigned NSLICE = WIDTH / 8;
    localparam int unsigned CW     = $clog2(WIDTH + 1);
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
            $error("popcount_seq: WIDTH must be a multiple of 8 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic             o_valid_q;
    logic             busy_q;
    logic [3:0]       slice_cnt;
    logic             accept;

    popcount8 u_pc8 (
        .d   (sh[7:0]),
        .cnt (slice_cnt)
    );

    // Ready to take a word when idle, or when the held result leaves this cycle.
    always_comb begin
        bus.I_ready = 1'b0;
        case (state)
            IDLE:    bus.I_ready = 1'b1;
            DONE:    bus.I_ready = bus.O_ready;
            default: bus.I_ready = 1'b0;
        endcase
    end

    assign accept      = bus.I_valid && bus.I_ready;
    assign bus.O_valid = o_valid_q;
    assign bus.O       = acc;
    assign busy        = busy_q;

    // Controller: load a word, accumulate NSLICE byte counts, hold the result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            sh        <= '0;
            acc       <= '0;
            idx       <= '0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh     <= bus.I;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc + CW'(slice_cnt);
                    sh  <= sh >> 8;
                    idx <= idx + IW'(1);
                    if (idx == IW'(NSLICE - 1)) begin
                        state     <= DONE;
                        o_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.O_ready) begin
                        o_valid_q <= 1'b0;
                        if (bus.I_valid) begin
                            sh    <= bus.I;
                            acc   <= '0;
                            idx   <= '0;
                            state <= RUN;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_seq.sv
// Directed and randomized checks for popcount_seq at WIDTH=32.
module tb_popcount_seq;
    logic CLK;
    logic RESET;
    logic busy;
    int   n_checks;
    int   n_fail;

    popcount_seq_if #(.WIDTH(32)) bus ();

    popcount_seq #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.I_valid = 1'b0;
        bus.I = '0;
        bus.O_ready = 1'b1;
        step();
        step();
        RESET = 1'b0;
        n_checks++;
        if (bus.I_ready !== 1'b1) begin n_fail++; $display("FAIL reset_I_ready got %b want 1", bus.I_ready); end
        n_checks++;
        if (bus.O_valid !== 1'b0) begin n_fail++; $display("FAIL reset_O_valid got %b want 0", bus.O_valid); end
        n_checks++;
        if (bus.O !== 6'd0) begin n_fail++; $display("FAIL reset_O got %0d want 0", bus.O); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [31:0] words [4];
        logic [5:0]  exp   [4];
        words[0] = 32'hFFFF_FFFF; exp[0] = 6'd32;
        words[1] = 32'h0000_0000; exp[1] = 6'd0;
        words[2] = 32'h8000_0001; exp[2] = 6'd2;
        words[3] = 32'h0F0F_00F0; exp[3] = 6'd12;
        for (int k = 0; k < 4; k++) begin
            bus.O_ready = 1'b1;
            bus.I_valid = 1'b1;
            bus.I = words[k];
            n_checks++;
            if (bus.I_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready[%0d] got %b want 1", k, bus.I_ready); end
            step();
            bus.I_valid = 1'b0;
            n_checks++;
            if (bus.I_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL basic_run_entry[%0d] I_ready=%b busy=%b want 0/1", k, bus.I_ready, busy);
            end
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (bus.O_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d] cycle %0d got %b want 0", k, c, bus.O_valid); end
                step();
            end
            n_checks++;
            if (bus.O_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d] cycle 3 got %b want 0", k, bus.O_valid); end
            step();
            n_checks++;
            if (bus.O_valid !== 1'b1 || bus.O !== exp[k]) begin
                n_fail++; $display("FAIL basic_result[%0d] O_valid=%b O=%0d want 1/%0d", k, bus.O_valid, bus.O, exp[k]);
            end
            step();
            n_checks++;
            if (bus.O_valid !== 1'b0 || busy !== 1'b0 || bus.I_ready !== 1'b1) begin
                n_fail++; $display("FAIL basic_back_idle[%0d] O_valid=%b busy=%b I_ready=%b want 0/0/1", k, bus.O_valid, busy, bus.I_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int waited;
        bus.O_ready = 1'b0;
        bus.I_valid = 1'b1;
        bus.I = 32'h1234_5678;
        step();
        bus.I_valid = 1'b0;
        waited = 0;
        while (bus.O_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_checks++;
        if (bus.O_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait_valid got %b want 1 (timeout)", bus.O_valid); end
        bus.I_valid = 1'b1;
        bus.I = 32'hFFFF_FFFF;
        #1;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (bus.O_valid !== 1'b1 || bus.O !== 6'd13 || bus.I_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d] O_valid=%b O=%0d I_ready=%b want 1/13/0", c, bus.O_valid, bus.O, bus.I_ready);
            end
            step();
        end
        bus.O_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.I_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.I_ready); end
        step();
        bus.I_valid = 1'b0;
        n_checks++;
        if (bus.O_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL bp_reload O_valid=%b busy=%b want 0/1", bus.O_valid, busy);
        end
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (bus.O_valid !== 1'b1 || bus.O !== 6'd32) begin
            n_fail++; $display("FAIL bp_second_result O_valid=%b O=%0d want 1/32", bus.O_valid, bus.O);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        logic [5:0]  exp   [3];
        int in_idx;
        int out_idx;
        int last_cyc;
        logic acc_now;
        words[0] = 32'h0000_0001; exp[0] = 6'd1;
        words[1] = 32'h0000_0003; exp[1] = 6'd2;
        words[2] = 32'h0000_0007; exp[2] = 6'd3;
        in_idx = 0;
        out_idx = 0;
        last_cyc = 0;
        bus.O_ready = 1'b1;
        bus.I_valid = 1'b1;
        bus.I = words[0];
        for (int cyc = 1; cyc <= 30; cyc++) begin
            #1;
            acc_now = bus.I_valid && bus.I_ready;
            step();
            if (acc_now) begin
                in_idx++;
                if (in_idx < 3) bus.I = words[in_idx];
                else bus.I_valid = 1'b0;
            end
            if (bus.O_valid === 1'b1) begin
                n_checks++;
                if (out_idx >= 3) begin
                    n_fail++; $display("FAIL b2b_extra_output got O=%0d want none", bus.O);
                end else begin
                    if (bus.O !== exp[out_idx]) begin
                        n_fail++; $display("FAIL b2b_value[%0d] got %0d want %0d", out_idx, bus.O, exp[out_idx]);
                    end
                    if (out_idx > 0) begin
                        n_checks++;
                        if (cyc - last_cyc != 5) begin
                            n_fail++; $display("FAIL b2b_spacing[%0d] got %0d want 5", out_idx, cyc - last_cyc);
                        end
                    end
                end
                last_cyc = cyc;
                out_idx++;
            end
        end
        n_checks++;
        if (out_idx != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", out_idx); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        bus.O_ready = 1'b1;
        bus.I_valid = 1'b1;
        bus.I = 32'hFFFF_FFFF;
        step();
        bus.I_valid = 1'b0;
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++;
        if (bus.I_ready !== 1'b1 || bus.O_valid !== 1'b0 || busy !== 1'b0 || bus.O !== 6'd0) begin
            n_fail++; $display("FAIL midrst_state I_ready=%b O_valid=%b busy=%b O=%0d want 1/0/0/0", bus.I_ready, bus.O_valid, busy, bus.O);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.O_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL midrst_ghost_valid got %0d pulses want 0", seen); end
        bus.I_valid = 1'b1;
        bus.I = 32'h0000_00FF;
        step();
        bus.I_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (bus.O_valid !== 1'b1 || bus.O !== 6'd8) begin
            n_fail++; $display("FAIL midrst_next_word O_valid=%b O=%0d want 1/8", bus.O_valid, bus.O);
        end
        step();
    endtask

    task automatic test_random();
        logic [5:0] sb [$];
        logic [5:0] want;
        int sent;
        int got;
        int cycles;
        sent = 0;
        got = 0;
        cycles = 0;
        while (got < 1000 && cycles < 50000) begin
            if (sent < 1000) begin
                bus.I_valid = ($urandom_range(0, 3) != 0);
                bus.I = $urandom;
            end else begin
                bus.I_valid = 1'b0;
            end
            bus.O_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.I_valid && bus.I_ready) begin
                sb.push_back(6'($countones(bus.I)));
                sent++;
            end
            if (bus.O_valid && bus.O_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected_output got O=%0d want no output", bus.O);
                end else begin
                    want = sb.pop_front();
                    if (bus.O !== want) begin
                        n_fail++; $display("FAIL rand_value[%0d] got %0d want %0d", got, bus.O, want);
                    end
                end
                got++;
            end
            step();
            cycles++;
        end
        bus.I_valid = 1'b0;
        n_checks++;
        if (got != 1000) begin n_fail++; $display("FAIL rand_completed got %0d want 1000 (cycle budget)", got); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        RESET = 1'b1;
        bus.I_valid = 1'b0;
        bus.I = '0;
        bus.O_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
